adder_sub_4bit: RTL and testbench



---
 rtl/adder_sub_4bit.sv | 76 +++++++
 tb/tb_adder_sub_4bit.sv | 106 ++++++++++
 2 files changed

// File: rtl/adder_sub_4bit.sv
// ---------------------------------------------------------------------------
// adder_sub_4bit
//   Registered 4-bit two's-complement adder/subtractor with signed-overflow
//   detection. M selects A+B (M=0) or A-B (M=1). Subtraction is done by
//   inverting B and injecting M as the carry-in. The sum goes through a
//   ripple chain of four full adders and is captured every rising clk edge.
//
// Ports
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-high reset (Y=0, Ovrflw=0)
//   A       in   4  operand A, two's complement
//   B       in   4  operand B, two's complement
//   M       in   1  mode: 0 = add, 1 = subtract
//   Y       out  4  registered result, modulo 16
//   Ovrflw  out  1  registered signed-overflow flag for the captured result
// ---------------------------------------------------------------------------

// One ripple stage.
module adder_sub_4bit_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module adder_sub_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       M,
    output logic [3:0] Y,
    output logic       Ovrflw
);
    localparam int W = 4;

    logic [W-1:0] bx;     // B conditioned by the mode bit
    logic [W:0]   c;      // c[0] = carry-in, c[W] = carry-out
    logic [W-1:0] s;
    logic         v;

    // Subtract is A + ~B + 1: the mode bit both inverts B and supplies the +1.
    assign bx   = B ^ {W{M}};
    assign c[0] = M;

    for (genvar i = 0; i < W; i++) begin : g_stage
        adder_sub_4bit_fa u_fa (
            .a  (A[i]),
            .b  (bx[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    // The unsigned carry/borrow c[W] is otherwise left internal.
    assign v = c[W-1] ^ c[W];

    always_ff @(posedge clk) begin
        if (rst) begin
            Y      <= '0;
            Ovrflw <= 1'b0;
        end else begin
            Y      <= s;
            Ovrflw <= v;
        end
    end
endmodule

// File: tb/tb_adder_sub_4bit.sv
module tb_adder_sub_4bit;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] A, B;
    logic       M;
    logic [3:0] Y;
    logic       Ovrflw;

    int ncmp  = 0;
    int nfail = 0;

    adder_sub_4bit dut (
        .clk    (clk),
        .rst    (rst),
        .A      (A),
        .B      (B),
        .M      (M),
        .Y      (Y),
        .Ovrflw (Ovrflw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] ey, input logic eo);
        ncmp++;
        assert (Y === ey) else begin
            nfail++;
            $error("FAIL %s Y: got %b want %b", tag, Y, ey);
        end
        ncmp++;
        assert (Ovrflw === eo) else begin
            nfail++;
            $error("FAIL %s Ovrflw: got %b want %b", tag, Ovrflw, eo);
        end
    endtask

    // Drive on the falling edge, let one rising edge capture, sample 1 after.
    task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                        input logic m);
        @(negedge clk);
        rst = r; A = a; B = b; M = m;
        @(posedge clk);
        #1;
    endtask

    // Signed reference: compute the true integer result, then wrap.
    task automatic ref_model(input logic [3:0] a, input logic [3:0] b, input logic m,
                             output logic [3:0] ey, output logic eo);
        int sa, sb, r;
        logic [31:0] ru;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = m ? (sa - sb) : (sa + sb);
        ru = r;
        ey = ru[3:0];
        eo = (r < -8) || (r > 7);
    endtask

    initial begin
        logic [3:0] ey;
        logic       eo;

        // Reset with arbitrary operands, then held with all-ones operands.
        step(1'b1, 4'b0110, 4'b0011, 1'b1);
        chk("reset", 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 4'b1111, 1'b0);
        chk("reset_hold", 4'b0000, 1'b0);

        // Directed vectors.
        step(1'b0, 4'b1001, 4'b0110, 1'b0); chk("add_m7p6", 4'b1111, 1'b0);
        step(1'b0, 4'b1001, 4'b0110, 1'b1); chk("sub_m7m6", 4'b0011, 1'b1);
        step(1'b0, 4'b0111, 4'b0001, 1'b0); chk("add_7p1", 4'b1000, 1'b1);
        step(1'b0, 4'b1000, 4'b1000, 1'b0); chk("add_m8pm8", 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 4'b1000, 1'b1); chk("sub_0mm8", 4'b1000, 1'b1);
        step(1'b0, 4'b0101, 4'b0101, 1'b1); chk("sub_5m5", 4'b0000, 1'b0);
        step(1'b0, 4'b1000, 4'b0001, 1'b1); chk("sub_m8m1", 4'b0111, 1'b1);
        step(1'b0, 4'b0011, 4'b0010, 1'b0); chk("add_3p2", 4'b0101, 1'b0);

        // Outputs hold when inputs change mid-cycle.
        A = 4'b0111; B = 4'b0111; M = 1'b0;
        #2;
        chk("hold_midcycle", 4'b0101, 1'b0);

        // Reset mid-stream, then first result one edge after deassert.
        step(1'b1, 4'b0111, 4'b0111, 1'b0); chk("reset_mid", 4'b0000, 1'b0);
        step(1'b0, 4'b0010, 4'b0011, 1'b1); chk("post_reset", 4'b1111, 1'b0);

        // Back-to-back exhaustive sweep: new operands every cycle.
        for (int k = 0; k < 512; k++) begin
            logic [8:0] v;
            v = 9'(k);
            step(1'b0, v[3:0], v[7:4], v[8]);
            ref_model(v[3:0], v[7:4], v[8], ey, eo);
            chk($sformatf("sweep_a%h_b%h_m%0d", v[3:0], v[7:4], v[8]), ey, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
